// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Function : Target end of the CPU's 8-bit load/store data interface.
//            It accepts one request at a time, inserts WAIT_CYCLES wait states
//            and returns the result on a valid/ready response channel.
//            Defining DMEM_ERR_EN flags out-of-range addresses instead of
//            wrapping them.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_rdata,
  output logic       resp_err
);

  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [7:0]  lat_addr;
  logic [7:0]  lat_wdata;
  logic [7:0]  mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          c_we;
  logic [7:0]    c_addr;
  logic [7:0]    c_wdata;
  logic [AW-1:0] c_idx;
  logic          c_err;
  logic          unused_addr;

  assign accept = req_valid && req_ready && (state == S_IDLE);

  // With no wait states the commit happens on the acceptance edge itself,
  // so the live request inputs are used instead of the latched copy.
  assign commit  = ZERO_WAIT ? accept : ((state == S_WAIT) && (cnt == 4'd0));
  assign c_we    = ZERO_WAIT ? req_we    : lat_we;
  assign c_addr  = ZERO_WAIT ? req_addr  : lat_addr;
  assign c_wdata = ZERO_WAIT ? req_wdata : lat_wdata;
  assign c_idx   = c_addr[AW-1:0];

`ifdef DMEM_ERR_EN
  assign c_err = ({1'b0, c_addr} >= 9'(DEPTH));
`else
  assign c_err = 1'b0;
`endif

  // Upper address bits only feed the error compare; parity keeps them referenced.
  assign unused_addr = ^c_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 8'd0;
      lat_wdata  <= 8'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 8'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (ZERO_WAIT) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          req_ready <= 1'b0;
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b0;
        end
      endcase

      if (commit) begin
        resp_err   <= c_err;
        resp_rdata <= (c_we || c_err) ? 8'd0 : mem[c_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
    end else if (commit && c_we && !c_err) begin
      mem[c_idx] <= c_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Function : Self-checking bench for dmem_responder (WAIT_CYCLES=2 and 0).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WAITS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [7:0] req_addr = 8'd0, req_wdata = 8'd0;
  logic       req_ready, resp_valid, resp_err;
  logic [7:0] resp_rdata;

  logic       z_req_valid = 1'b0, z_req_we = 1'b0, z_resp_ready = 1'b1;
  logic [7:0] z_req_addr = 8'd0, z_req_wdata = 8'd0;
  logic       z_req_ready, z_resp_valid, z_resp_err;
  logic [7:0] z_resp_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         stall;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what a transaction should return, from the address rules.
  task automatic model_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           output logic [7:0] rd, output logic er);
    int idx;
    idx = addr % DEPTH;
    er  = 1'b0;
    rd  = 8'd0;
`ifdef DMEM_ERR_EN
    if (addr >= DEPTH) begin
      er = 1'b1;
      return;
    end
`endif
    if (we) model_mem[idx] = wdata;
    else    rd = model_mem[idx];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'd0;
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance, checking handshake timing.
  task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                     input int stall, output logic [7:0] rd, output logic er);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", int'(req_ready), 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 40);
    check("latency", lat, WAITS + 1);
    check("busy_ready", int'(req_ready), 0);
    rd = resp_rdata;
    er = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", int'(resp_valid), 1);
      check("stall_rdata", int'(resp_rdata), int'(rd));
      check("stall_ready", int'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_valid", int'(resp_valid), 0);
    check("post_hs_ready", int'(req_ready), 1);
  endtask

  vec_t vecs [9];

  initial begin
    logic [7:0] rd, mrd;
    logic       er, mer;

`ifdef DMEM_ERR_EN
    vecs[0] = '{1'b0, 8'd5,  8'h00, 0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'd10, 8'hA5, 0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'd10, 8'h00, 0, 8'hA5, 1'b0};
    vecs[3] = '{1'b0, 8'd10, 8'h00, 5, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 8'd70, 8'h11, 0, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 8'd6,  8'h00, 0, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 8'd0,  8'hFF, 0, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 8'd64, 8'h00, 0, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 8'd0,  8'h00, 2, 8'hFF, 1'b0};
`else
    vecs[0] = '{1'b0, 8'd5,  8'h00, 0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'd10, 8'hA5, 0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'd10, 8'h00, 0, 8'hA5, 1'b0};
    vecs[3] = '{1'b0, 8'd10, 8'h00, 5, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 8'd70, 8'h11, 0, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 8'd6,  8'h00, 0, 8'h11, 1'b0};
    vecs[6] = '{1'b1, 8'd0,  8'hFF, 0, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 8'd64, 8'h00, 0, 8'hFF, 1'b0};
    vecs[8] = '{1'b0, 8'd0,  8'h00, 2, 8'hFF, 1'b0};
`endif

    // Reset held for three cycles.
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_rdata", int'(resp_rdata), 0);
    check("rst_err", int'(resp_err), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_req_ready", int'(req_ready), 1);
    check("idle_resp_valid", int'(resp_valid), 0);
    check("idle_rdata", int'(resp_rdata), 0);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall, rd, er);
      model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, mrd, mer);
      check($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), int'(er), int'(vecs[i].exp_err));
    end

    // Randomised traffic against the reference model; addresses biased to collide.
    for (int i = 0; i < 40; i++) begin
      logic       we;
      logic [7:0] addr, wdata;
      we    = 1'($urandom);
      addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      wdata = 8'($urandom);
      txn(we, addr, wdata, int'($urandom_range(0, 3)), rd, er);
      model_txn(we, addr, wdata, mrd, mer);
      check($sformatf("rnd%0d_rdata", i), int'(rd), int'(mrd));
      check($sformatf("rnd%0d_err", i), int'(er), int'(mer));
    end

    // Reset one cycle after accepting a store: it must vanish without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd2; req_wdata = 8'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", int'(resp_valid), 0);
    check("midrst_ready", int'(req_ready), 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_resp", int'(resp_valid), 0);
    end
    check("midrst_idle_ready", int'(req_ready), 1);
    txn(1'b0, 8'd2, 8'h00, 0, rd, er);
    check("midrst_mem2", int'(rd), 0);

    // Zero-wait instance, request held valid back-to-back.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 8'd63; z_req_wdata = 8'h3C;
    begin
      int n;
      n = 0;
      while (!z_req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("z_ready", int'(z_req_ready), 1);
    @(posedge clk);
    #1;
    z_req_we = 1'b0; z_req_wdata = 8'h00;
    @(negedge clk);
    check("z_store_valid", int'(z_resp_valid), 1);
    check("z_store_rdata", int'(z_resp_rdata), 0);
    check("z_store_busy", int'(z_req_ready), 0);
    @(negedge clk);
    check("z_gap_valid", int'(z_resp_valid), 0);
    check("z_gap_ready", int'(z_req_ready), 1);
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    check("z_load_valid", int'(z_resp_valid), 1);
    check("z_load_rdata", int'(z_resp_rdata), 8'h3C);
    check("z_load_err", int'(z_resp_err), 0);
    @(negedge clk);
    check("z_done_valid", int'(z_resp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
